// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result stage.
// ALU_PARITY_EN adds a parity bit to each buffered result entry.
package alu_pkg;

  localparam int ALU_W = 32;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [ALU_W-1:0] result;
    logic             zero;
    logic             neg;
    logic [TAG_W-1:0] tag;
`ifdef ALU_PARITY_EN
    logic             parity;
`endif
  } result_entry_t;

  function automatic logic even_parity(input logic [ALU_W-1:0] value);
    even_parity = ^value;
  endfunction

endpackage

// File: rtl/alu_fifo.sv
// Generic DEPTH-entry circular buffer with registered ready, valid and head data.
// The head register holds the last popped entry while the buffer is empty.
module alu_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_nxt_s;
  logic [PTR_W-1:0] rd_ptr_nxt_s;
  logic [OCC_W-1:0] occ_r;
  logic [OCC_W-1:0] occ_nxt_s;
  logic             ready_r;
  logic             valid_r;
  logic [W-1:0]     head_r;
  logic [W-1:0]     head_nxt_s;
  logic             push_s;
  logic             pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = ptr + PTR_W'(1);
    end
  endfunction

  assign push_s     = push_valid && ready_r;
  assign pop_s      = valid_r && pop_ready;
  assign push_ready = ready_r;
  assign pop_valid  = valid_r;
  assign pop_data   = head_r;

  // Next pointers, occupancy and the entry that will sit at the head after this edge.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    occ_nxt_s    = occ_r;
    head_nxt_s   = head_r;
    if (push_s) begin
      wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   occ_nxt_s = occ_r + OCC_W'(1);
      2'b01:   occ_nxt_s = occ_r - OCC_W'(1);
      default: occ_nxt_s = occ_r;
    endcase
    // The entry being written this edge is not yet in mem_r, so forward it.
    if (occ_nxt_s == '0) begin
      head_nxt_s = head_r;
    end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = push_data;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and registered handshake/head outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
      ready_r  <= 1'b1;
      valid_r  <= 1'b0;
      head_r   <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      occ_r    <= occ_nxt_s;
      ready_r  <= (occ_nxt_s != OCC_W'(DEPTH));
      valid_r  <= (occ_nxt_s != '0);
      head_r   <= head_nxt_s;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: buffers results for writeback, tracks sticky zero and accepted count.
// ALU_PARITY_EN adds out_parity, the XOR of the result captured at push.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ALU_W-1:0] in_result,
  input  logic             in_zero,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ALU_W-1:0] out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic [TAG_W-1:0] out_tag,
`ifdef ALU_PARITY_EN
  output logic             out_parity,
`endif
  input  logic             clr_sticky,
  output logic             sticky_zero,
  output logic [CNT_W-1:0] acc_count
);

  localparam int ENTRY_W = $bits(result_entry_t);

  result_entry_t      entry_in_s;
  result_entry_t      head_s;
  logic [ENTRY_W-1:0] head_bits_s;
  logic               push_s;
  logic               sticky_r;
  logic [CNT_W-1:0]   acc_r;

  // Pack the incoming result with its derived flags.
  always_comb begin
    entry_in_s        = '0;
    entry_in_s.result = in_result;
    entry_in_s.zero   = in_zero;
    entry_in_s.neg    = in_result[ALU_W-1];
    entry_in_s.tag    = in_tag;
`ifdef ALU_PARITY_EN
    entry_in_s.parity = even_parity(in_result);
`endif
  end

  alu_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (entry_in_s),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (head_bits_s)
  );

  assign push_s      = in_valid && in_ready;
  assign head_s      = head_bits_s;
  assign out_result  = head_s.result;
  assign out_zero    = head_s.zero;
  assign out_neg     = head_s.neg;
  assign out_tag     = head_s.tag;
`ifdef ALU_PARITY_EN
  assign out_parity  = head_s.parity;
`endif
  assign sticky_zero = sticky_r;
  assign acc_count   = acc_r;

  // Sticky zero (set beats clear) and the wrapping accepted-result counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_r <= 1'b0;
      acc_r    <= '0;
    end else begin
      if (push_s && in_zero) begin
        sticky_r <= 1'b1;
      end else if (clr_sticky) begin
        sticky_r <= 1'b0;
      end else begin
        sticky_r <= sticky_r;
      end
      if (push_s) begin
        acc_r <= acc_r + CNT_W'(1);
      end else begin
        acc_r <= acc_r;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: queue-based model checked every cycle plus directed literal checks.
module tb_alu_result_stage;

  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic [3:0]  tag;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_zero;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_neg;
  logic [3:0]  out_tag;
`ifdef ALU_PARITY_EN
  logic        out_parity;
`endif
  logic        clr_sticky;
  logic        sticky_zero;
  logic [15:0] acc_count;

  int n_checks = 0;
  int n_errors = 0;

  alu_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_zero     (in_zero),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_neg     (out_neg),
    .out_tag     (out_tag),
`ifdef ALU_PARITY_EN
    .out_parity  (out_parity),
`endif
    .clr_sticky  (clr_sticky),
    .sticky_zero (sticky_zero),
    .acc_count   (acc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a queue of accepted entries plus the last entry that left the head.
  ent_t        q[$];
  ent_t        m_last;
  int          m_size;
  logic        m_sticky;
  logic [15:0] m_count;
  wire         m_push = in_valid && (m_size < DEPTH);
  wire         m_pop  = (m_size != 0) && out_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_last   <= '{32'h0, 1'b0, 4'h0};
      m_size   <= 0;
      m_sticky <= 1'b0;
      m_count  <= 16'h0;
    end else begin
      case ({m_push, m_pop})
        2'b11: begin
          m_last <= q[0];
          q.delete(0);
          q.push_back('{in_result, in_zero, in_tag});
        end
        2'b10: begin
          q.push_back('{in_result, in_zero, in_tag});
          m_size <= m_size + 1;
        end
        2'b01: begin
          m_last <= q[0];
          q.delete(0);
          m_size <= m_size - 1;
        end
        default: ;
      endcase
      if (m_push && in_zero) m_sticky <= 1'b1;
      else if (clr_sticky) m_sticky <= 1'b0;
      if (m_push) m_count <= m_count + 16'h1;
    end
  end

  function automatic ent_t exp_head();
    if (q.size() != 0) return q[0];
    return m_last;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    chk("out_valid", {31'h0, out_valid}, {31'h0, (q.size() != 0)});
    chk("in_ready", {31'h0, in_ready}, {31'h0, (q.size() < DEPTH)});
    chk("out_result", out_result, exp_head().result);
    chk("out_zero", {31'h0, out_zero}, {31'h0, exp_head().zero});
    chk("out_neg", {31'h0, out_neg}, {31'h0, exp_head().result[31]});
    chk("out_tag", {28'h0, out_tag}, {28'h0, exp_head().tag});
`ifdef ALU_PARITY_EN
    chk("out_parity", {31'h0, out_parity}, {31'h0, ^exp_head().result});
`endif
    chk("sticky_zero", {31'h0, sticky_zero}, {31'h0, m_sticky});
    chk("acc_count", {16'h0, acc_count}, {16'h0, m_count});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic z, input logic [3:0] t);
    in_valid  = v;
    in_result = r;
    in_zero   = z;
    in_tag    = t;
  endtask

  initial begin
    rst_n      = 1'b0;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 4'h0);
    cyc();
    cyc();
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_acc", {16'h0, acc_count}, 32'h0);
    chk("rst_out_result", out_result, 32'h0);
    rst_n = 1'b1;
    cyc();

    // Single push, one cycle latency.
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_0010, 1'b0, 4'h3);
    cyc();
    drive(1'b0, 32'h0, 1'b0, 4'h0);
    chk("lat_valid", {31'h0, out_valid}, 32'h1);
    chk("lat_result", out_result, 32'h10);
    chk("lat_neg", {31'h0, out_neg}, 32'h0);
    chk("lat_tag", {28'h0, out_tag}, 32'h3);
    chk("lat_acc", {16'h0, acc_count}, 32'h1);
    cyc();
    out_ready = 1'b0;

    // Fill under backpressure, then an ignored third push.
    drive(1'b1, 32'h8000_0000, 1'b0, 4'h1);
    cyc();
    drive(1'b1, 32'h0000_0001, 1'b0, 4'h2);
    cyc();
    chk("full_ready", {31'h0, in_ready}, 32'h0);
    chk("full_neg", {31'h0, out_neg}, 32'h1);
    chk("full_head", out_result, 32'h8000_0000);
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 4'hF);
    cyc();
    drive(1'b0, 32'h0, 1'b0, 4'h0);
    chk("full_acc", {16'h0, acc_count}, 32'h3);

    // Pop from full: ready stays low during the pop cycle.
    out_ready = 1'b1;
    chk("pop_ready_during", {31'h0, in_ready}, 32'h0);
    cyc();
    out_ready = 1'b0;
    chk("pop_ready_after", {31'h0, in_ready}, 32'h1);
    chk("pop_head", out_result, 32'h1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("empty_valid", {31'h0, out_valid}, 32'h0);
    chk("empty_hold", out_result, 32'h1);

    // Sticky set wins over clear; zero flag is stored as given.
    clr_sticky = 1'b1;
    drive(1'b1, 32'h0, 1'b1, 4'h5);
    cyc();
    clr_sticky = 1'b0;
    drive(1'b1, 32'h0000_0005, 1'b1, 4'h6);
    cyc();
    drive(1'b0, 32'h0, 1'b0, 4'h0);
    chk("sticky_set", {31'h0, sticky_zero}, 32'h1);
    cyc();
    clr_sticky = 1'b1;
    cyc();
    clr_sticky = 1'b0;
    chk("sticky_clr", {31'h0, sticky_zero}, 32'h0);
    out_ready = 1'b1;
    chk("zero_kept", {31'h0, out_zero}, 32'h1);
    cyc();
    chk("zero_nonzero_res", {31'h0, out_zero}, 32'h1);
    chk("zero_res", out_result, 32'h5);
    cyc();

    // Mixed traffic with toggling backpressure.
    for (int i = 0; i < 16; i++) begin
      out_ready = (i % 3) != 0;
      drive((i % 4) != 3, 32'hA5A5_0000 + 32'(i * 77), (i % 5) == 0, 4'(i));
      cyc();
    end
    drive(1'b0, 32'h0, 1'b0, 4'h0);
    out_ready = 1'b0;

    // Async reset with two entries queued.
    drive(1'b1, 32'h1111_1111, 1'b0, 4'h1);
    cyc();
    drive(1'b1, 32'h2222_2222, 1'b0, 4'h2);
    cyc();
    drive(1'b0, 32'h0, 1'b0, 4'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'h0, out_valid}, 32'h0);
    chk("arst_ready", {31'h0, in_ready}, 32'h1);
    chk("arst_acc", {16'h0, acc_count}, 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Continuous flow to the counter wrap.
    out_ready = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      drive(1'b1, {i[15:0], 16'h0} ^ 32'(i), (i % 7) == 0, 4'(i));
      cyc();
    end
    drive(1'b0, 32'h0, 1'b0, 4'h0);
    chk("wrap_pre", {16'h0, acc_count}, 32'hFFFF);
    drive(1'b1, 32'h0000_0042, 1'b0, 4'h4);
    cyc();
    drive(1'b0, 32'h0, 1'b0, 4'h0);
    chk("wrap_post", {16'h0, acc_count}, 32'h0);
    cyc();

`ifdef ALU_PARITY_EN
    drive(1'b1, 32'h0000_0007, 1'b0, 4'h7);
    cyc();
    drive(1'b0, 32'h0, 1'b0, 4'h0);
    chk("parity_7", {31'h0, out_parity}, 32'h1);
    cyc();
`endif

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
